// File: rtl/plab4_net_tdm_pkg.sv
// rtl/plab4_net_tdm_pkg.sv - shared constants and helpers for the TDM output-port arbiter
package plab4_net_tdm_pkg;

  localparam logic DOMAIN_D1 = 1'b0;
  localparam logic DOMAIN_D2 = 1'b1;

  localparam int NUM_IN_PORTS = 3;

  localparam logic [NUM_IN_PORTS-1:0] PRIO_RESET = 3'b001;

  // Next input-port index in round-robin order, wrapping 2 -> 0
  function automatic logic [1:0] next_port(input logic [1:0] port);
    return (port == 2'd2) ? 2'd0 : port + 2'd1;
  endfunction

  // One-hot rotate left by one position (3'b100 -> 3'b001)
  function automatic logic [NUM_IN_PORTS-1:0] rotl1(input logic [NUM_IN_PORTS-1:0] v);
    return {v[NUM_IN_PORTS-2:0], v[NUM_IN_PORTS-1]};
  endfunction

endpackage

// File: rtl/plab4_net_rr_prio_arb3.sv
// rtl/plab4_net_rr_prio_arb3.sv - combinational 3-input round-robin arbiter with one-hot priority
module plab4_net_rr_prio_arb3
  import plab4_net_tdm_pkg::*;
(
  input  logic [NUM_IN_PORTS-1:0] i_reqs,
  input  logic [NUM_IN_PORTS-1:0] i_prio,
  output logic [NUM_IN_PORTS-1:0] o_grants
);

  logic [1:0] w_idx0;
  logic [1:0] w_idx1;
  logic [1:0] w_idx2;

  // Convert the one-hot priority into the index where the search starts
  always_comb begin
    w_idx0 = 2'd0;
    if (i_prio[1]) begin
      w_idx0 = 2'd1;
    end else if (i_prio[2]) begin
      w_idx0 = 2'd2;
    end
  end

  assign w_idx1 = next_port(w_idx0);
  assign w_idx2 = next_port(w_idx1);

  // Grant the first requester found walking upward from the priority position
  always_comb begin
    o_grants = '0;
    if (i_reqs[w_idx0]) begin
      o_grants[w_idx0] = 1'b1;
    end else if (i_reqs[w_idx1]) begin
      o_grants[w_idx1] = 1'b1;
    end else if (i_reqs[w_idx2]) begin
      o_grants[w_idx2] = 1'b1;
    end
  end

endmodule

// File: rtl/plab4_net_router_tdm_out_arb.sv
// rtl/plab4_net_router_tdm_out_arb.sv - per-output-port arbiter with a fixed TDM domain schedule
module plab4_net_router_tdm_out_arb
  import plab4_net_tdm_pkg::*;
#(
  parameter int p_slot_cycles  = 4,
  parameter int p_guard_cycles = 0
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_PORTS-1:0] reqs_d0,
  input  logic [NUM_IN_PORTS-1:0] reqs_d1,
  input  logic                    out_rdy,
  output logic [NUM_IN_PORTS-1:0] grants,
  output logic                    grant_val,
  output logic                    domain
);

  localparam int c_slot_nbits = $clog2(p_slot_cycles + 1);

  // Counter width has one spare value so the guard start equals p_slot_cycles when there is no guard
  localparam logic [c_slot_nbits-1:0] C_SLOT_LAST   = c_slot_nbits'(p_slot_cycles - 1);
  localparam logic [c_slot_nbits-1:0] C_GUARD_START = c_slot_nbits'(p_slot_cycles - p_guard_cycles);

  logic                    r_domain_q;
  logic [c_slot_nbits-1:0] r_slot_cnt_q;
  logic [NUM_IN_PORTS-1:0] r_prio_d0_q;
  logic [NUM_IN_PORTS-1:0] r_prio_d1_q;

  logic [NUM_IN_PORTS-1:0] w_reqs;
  logic [NUM_IN_PORTS-1:0] w_prio;
  logic [NUM_IN_PORTS-1:0] w_arb_grants;
  logic [NUM_IN_PORTS-1:0] w_grants;
  logic                    w_guard;

  // Slot counter and domain owner advance on every cycle regardless of traffic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt_q <= '0;
      r_domain_q   <= DOMAIN_D1;
    end else if (r_slot_cnt_q == C_SLOT_LAST) begin
      r_slot_cnt_q <= '0;
      r_domain_q   <= ~r_domain_q;
    end else begin
      r_slot_cnt_q <= r_slot_cnt_q + 1'b1;
    end
  end

  assign w_guard = (r_slot_cnt_q >= C_GUARD_START);

  // Only the slot owner's requests and priority reach the shared arbiter
  always_comb begin
    w_reqs = reqs_d0;
    w_prio = r_prio_d0_q;
    if (r_domain_q == DOMAIN_D2) begin
      w_reqs = reqs_d1;
      w_prio = r_prio_d1_q;
    end
  end

  plab4_net_rr_prio_arb3 u_arb (
    .i_reqs   (w_reqs),
    .i_prio   (w_prio),
    .o_grants (w_arb_grants)
  );

  // Suppress grants during reset, backpressure and the guard tail of the slot
  always_comb begin
    w_grants = w_arb_grants;
    if (reset || !out_rdy || w_guard) begin
      w_grants = '0;
    end
  end

  // Winner moves to lowest priority; only the domain that issued the grant updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio_d0_q <= PRIO_RESET;
      r_prio_d1_q <= PRIO_RESET;
    end else if (|w_grants) begin
      if (r_domain_q == DOMAIN_D2) begin
        r_prio_d1_q <= rotl1(w_grants);
      end else begin
        r_prio_d0_q <= rotl1(w_grants);
      end
    end
  end

  assign grants    = w_grants;
  assign grant_val = |w_grants;
  assign domain    = r_domain_q;

endmodule

// File: tb/tb_plab4_net_router_tdm_out_arb.sv
// tb/tb_plab4_net_router_tdm_out_arb.sv - directed self-checking bench for the TDM output arbiter
module tb_plab4_net_router_tdm_out_arb;

  logic       clk;
  logic       reset;
  logic [2:0] reqs_d0;
  logic [2:0] reqs_d1;
  logic       out_rdy;

  logic [2:0] grants_a;
  logic       gv_a;
  logic       dom_a;
  logic [2:0] grants_b;
  logic       gv_b;
  logic       dom_b;

  int n_vec;
  int n_err;
  int cyc;

  // Unguarded instance
  plab4_net_router_tdm_out_arb #(.p_slot_cycles(4), .p_guard_cycles(0)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .reqs_d0   (reqs_d0),
    .reqs_d1   (reqs_d1),
    .out_rdy   (out_rdy),
    .grants    (grants_a),
    .grant_val (gv_a),
    .domain    (dom_a)
  );

  // One guard cycle at the end of each slot
  plab4_net_router_tdm_out_arb #(.p_slot_cycles(4), .p_guard_cycles(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .reqs_d0   (reqs_d0),
    .reqs_d1   (reqs_d1),
    .out_rdy   (out_rdy),
    .grants    (grants_b),
    .grant_val (gv_b),
    .domain    (dom_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // One reset pulse covering a rising edge; returns at cycle 0 of a fresh schedule
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset   = 1'b1;
    reqs_d0 = 3'b000;
    reqs_d1 = 3'b000;
    out_rdy = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    cyc   = 0;
  endtask

  logic [17:0] dom_seq;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    reset   = 1'b1;
    reqs_d0 = 3'b000;
    reqs_d1 = 3'b000;
    out_rdy = 1'b0;
    dom_seq = 18'h0F0F0;

    // Reset and async reset mid-slot
    do_reset();
    reqs_d0 = 3'b111;
    out_rdy = 1'b1;
    #1;
    chk("reset_domain", {3'b0, dom_a}, 4'h0);
    chk("first_grant", {1'b0, grants_a}, 4'h1);
    nxt();
    #1;
    chk("rr_c1_pre_reset", {1'b0, grants_a}, 4'h2);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_grants", {1'b0, grants_a}, 4'h0);
    chk("async_rst_gv", {3'b0, gv_a}, 4'h0);
    chk("async_rst_grants_b", {1'b0, grants_b}, 4'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    cyc   = 0;
    #1;
    chk("post_rst_domain", {3'b0, dom_a}, 4'h0);
    chk("post_rst_grant", {1'b0, grants_a}, 4'h1);
    chk("post_rst_gv", {3'b0, gv_a}, 4'h1);

    // Round-robin rotation within one domain-0 slot
    nxt(); #1;
    chk("rr_c1", {1'b0, grants_a}, 4'h2);
    chk("rr_c1_b", {1'b0, grants_b}, 4'h2);
    nxt(); #1;
    chk("rr_c2", {1'b0, grants_a}, 4'h4);
    chk("rr_c2_b", {1'b0, grants_b}, 4'h4);
    nxt(); #1;
    chk("rr_c3_wrap", {1'b0, grants_a}, 4'h1);
    chk("guard_blocks_c3", {1'b0, grants_b}, 4'h0);
    chk("guard_gv_c3", {3'b0, gv_b}, 4'h0);

    // Domain schedule is independent of requests and out_rdy
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i > 0) nxt();
      if (i >= 10) begin
        reqs_d0 = 3'b111;
        reqs_d1 = 3'b111;
        out_rdy = cyc[0];
      end
      #1;
      chk("tdm_domain_a", {3'b0, dom_a}, {3'b0, dom_seq[i]});
      chk("tdm_domain_b", {3'b0, dom_b}, {3'b0, dom_seq[i]});
      if (i < 10) chk("tdm_idle_gv", {3'b0, gv_a}, 4'h0);
    end

    // Isolation between domains
    do_reset();
    reqs_d1 = 3'b010;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      #1;
      chk("iso_d0_slot", {1'b0, grants_a}, 4'h0);
    end
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("iso_d1_domain", {3'b0, dom_a}, 4'h1);
      chk("iso_d1_grant", {1'b0, grants_a}, 4'h2);
    end
    nxt();
    reqs_d0 = 3'b111;
    #1;
    chk("iso_prio_d0_kept", {1'b0, grants_a}, 4'h1);

    // Backpressure and guard on the guarded instance
    do_reset();
    reqs_d0 = 3'b111;
    out_rdy = 1'b0;
    #1;
    chk("bp_c0", {1'b0, grants_b}, 4'h0);
    nxt(); #1;
    chk("bp_c1", {1'b0, grants_b}, 4'h0);
    nxt();
    out_rdy = 1'b1;
    #1;
    chk("bp_prio_kept", {1'b0, grants_b}, 4'h1);
    nxt(); #1;
    chk("guard_c3", {1'b0, grants_b}, 4'h0);
    chk("noguard_c3", {1'b0, grants_a}, 4'h2);

    // Grant on the last slot cycle, then hand-over to the other domain
    do_reset();
    reqs_d0 = 3'b001;
    out_rdy = 1'b1;
    #1;
    chk("bnd_c0", {1'b0, grants_a}, 4'h1);
    nxt();
    reqs_d0 = 3'b010;
    #1;
    chk("bnd_c1", {1'b0, grants_a}, 4'h2);
    nxt();
    out_rdy = 1'b0;
    #1;
    chk("bnd_c2_stall", {1'b0, grants_a}, 4'h0);
    nxt();
    reqs_d0 = 3'b100;
    reqs_d1 = 3'b001;
    out_rdy = 1'b1;
    #1;
    chk("bnd_last_grant", {1'b0, grants_a}, 4'h4);
    nxt();
    reqs_d1 = 3'b111;
    #1;
    chk("bnd_next_domain", {3'b0, dom_a}, 4'h1);
    chk("bnd_d1_grant", {1'b0, grants_a}, 4'h1);
    nxt();
    reqs_d1 = 3'b000;
    nxt();
    nxt();
    nxt();
    reqs_d0 = 3'b111;
    #1;
    chk("bnd_back_domain", {3'b0, dom_a}, 4'h0);
    chk("bnd_prio_wrap", {1'b0, grants_a}, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
